bp_me_wormhole_stream_encode: RTL and testbench

- Parametrised, sequential successor to the LCE-response wormhole header encoder.
- Accepts one coherence message per handshake: message header, optional data payload and size.
- Computes the wormhole header {msg_hdr, cid, len, cord} and buffers header plus data.
- Serializes the packet into flits on a ready/valid link toward the coherence NoC adapter; supports back-to-back packets with no bubble.

---
 rtl/bp_me_wormhole_pkg.sv | 22 ++
 rtl/bp_me_wormhole_len_calc.sv | 48 ++++
 rtl/bp_me_wormhole_stream_encode.sv | 160 ++++++++++++++++
 tb/tb_bp_me_wormhole_stream_encode.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/bp_me_wormhole_pkg.sv
// Shared state type, header-width macro and flit-count helper for the wormhole
// stream encoder and the decode-side checkers that reuse its length logic.
`ifndef BP_ME_WORMHOLE_PKG_SV
`define BP_ME_WORMHOLE_PKG_SV

`define BP_ME_WH_HEADER_WIDTH(cord_mp, len_mp, cid_mp, msg_mp) \
   ((cord_mp) + (len_mp) + (cid_mp) + (msg_mp))

package bp_me_wormhole_pkg;

   typedef enum logic [0:0] {
      e_ready = 1'b0,
      e_send  = 1'b1
   } bp_me_wh_enc_state_e;

   function automatic int bp_me_wh_flit_count(input int bits_i, input int flit_width_i);
      return (bits_i + flit_width_i - 1) / flit_width_i;
   endfunction

endpackage

`endif

// File: rtl/bp_me_wormhole_len_calc.sv
// Wormhole length calculator: {has_data, size} -> {len, payload bytes, illegal}.
// Oversized requests are clamped to the largest payload and flagged.
module bp_me_wormhole_len_calc
   import bp_me_wormhole_pkg::*;
#(
   parameter int flit_width_p     = 64,
   parameter int header_width_p   = 93,
   parameter int len_width_p      = 4,
   parameter int max_data_bytes_p = 64,
   parameter int size_width_p     = 3
)
(
   input  logic                    has_data_i,
   input  logic [size_width_p-1:0] size_i,
   output logic [len_width_p-1:0]  len_o,
   output logic [31:0]             bytes_o,
   output logic                    illegal_o
);

   localparam int max_size_lp = $clog2(max_data_bytes_p);
   localparam int len_max_lp  = (1 << len_width_p) - 1;

   logic [31:0] size_ext_s;
   logic [31:0] eff_size_s;
   logic [31:0] len_full_s;
   logic        size_bad_s;

   // Clamp the size, then derive the full-width length before truncation.
   always_comb begin
      size_ext_s = 32'(size_i);
      size_bad_s = has_data_i && (size_ext_s > 32'(max_size_lp));
      if (size_bad_s) begin
         eff_size_s = 32'(max_size_lp);
      end else begin
         eff_size_s = size_ext_s;
      end
      if (has_data_i) begin
         bytes_o = 32'd1 << eff_size_s;
      end else begin
         bytes_o = 32'd0;
      end
      len_full_s = 32'(bp_me_wh_flit_count(header_width_p + 8 * int'(bytes_o), flit_width_p))
                   - 32'd1;
      len_o      = len_full_s[len_width_p-1:0];
      illegal_o  = size_bad_s || (len_full_s > 32'(len_max_lp));
   end

endmodule

// File: rtl/bp_me_wormhole_stream_encode.sv
// Buffers one coherence message with its wormhole header and streams it LSB-first
// as flits. Optional sticky err_o output is enabled by BP_ME_WH_ENCODE_ERR_EN.
module bp_me_wormhole_stream_encode
   import bp_me_wormhole_pkg::*;
#(
   parameter int flit_width_p     = 64,
   parameter int cord_width_p     = 7,
   parameter int len_width_p      = 4,
   parameter int cid_width_p      = 2,
   parameter int msg_hdr_width_p  = 80,
   parameter int max_data_bytes_p = 64,
   parameter int size_width_p     = 3
)
(
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic [msg_hdr_width_p-1:0]    msg_hdr_i,
   input  logic [max_data_bytes_p*8-1:0] data_i,
   input  logic                          has_data_i,
   input  logic [size_width_p-1:0]       size_i,
   input  logic [cord_width_p-1:0]       cord_i,
   input  logic [cid_width_p-1:0]        cid_i,
   input  logic                          v_i,
   output logic                          ready_o,
   output logic [flit_width_p-1:0]       link_data_o,
   output logic                          link_v_o,
   input  logic                          link_ready_i
`ifdef BP_ME_WH_ENCODE_ERR_EN
   ,output logic                         err_o
`endif
);

   localparam int header_width_lp = `BP_ME_WH_HEADER_WIDTH(cord_width_p, len_width_p,
                                                           cid_width_p, msg_hdr_width_p);
   localparam int data_width_lp   = max_data_bytes_p * 8;
   localparam int pkt_width_lp    = header_width_lp + data_width_lp;
   localparam int num_flits_lp    = bp_me_wh_flit_count(pkt_width_lp, flit_width_p);
   localparam int buf_width_lp    = num_flits_lp * flit_width_p;

   bp_me_wh_enc_state_e     state_q, state_d;
   logic [len_width_p-1:0]  cnt_q, cnt_d;
   logic [len_width_p-1:0]  len_q, len_d;
   logic [buf_width_lp-1:0] buf_q, buf_d;

   logic [buf_width_lp-1:0]  pkt_s;
   logic [data_width_lp-1:0] data_mask_s;
   logic [len_width_p-1:0]   len_s;
   logic [31:0]              bytes_s;
   logic                     illegal_s;
   logic                     accept_s;

   bp_me_wormhole_len_calc #(
      .flit_width_p     (flit_width_p),
      .header_width_p   (header_width_lp),
      .len_width_p      (len_width_p),
      .max_data_bytes_p (max_data_bytes_p),
      .size_width_p     (size_width_p)
   ) len_calc (
      .has_data_i (has_data_i),
      .size_i     (size_i),
      .len_o      (len_s),
      .bytes_o    (bytes_s),
      .illegal_o  (illegal_s)
   );

   // Bytes beyond the payload size are zeroed so stale upper data never leaks.
   always_comb begin
      data_mask_s = '0;
      for (int b = 0; b < max_data_bytes_p; b++) begin
         if (32'(b) < bytes_s) begin
            data_mask_s[b*8 +: 8] = 8'hFF;
         end else begin
            data_mask_s[b*8 +: 8] = 8'h00;
         end
      end
      pkt_s = '0;
      pkt_s[pkt_width_lp-1:0] = {data_i & data_mask_s, msg_hdr_i, cid_i, len_s, cord_i};
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      len_d    = len_q;
      buf_d    = buf_q;
      ready_o  = 1'b0;
      link_v_o = 1'b0;
      case (state_q)
         e_ready: begin
            ready_o = 1'b1;
         end
         e_send: begin
            link_v_o = 1'b1;
            if (link_ready_i) begin
               if (cnt_q == len_q) begin
                  ready_o = 1'b1;
                  state_d = e_ready;
               end else begin
                  cnt_d = cnt_q + len_width_p'(1);
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
         default: begin
            state_d = e_ready;
         end
      endcase
      // A load on the last flit keeps the stream in e_send with no bubble.
      accept_s = v_i & ready_o;
      if (accept_s) begin
         state_d = e_send;
         buf_d   = pkt_s;
         len_d   = len_s;
         cnt_d   = '0;
      end else begin
         buf_d   = buf_q;
      end
   end

   always_comb begin
      link_data_o = '0;
      for (int k = 0; k < num_flits_lp; k++) begin
         link_data_o = link_data_o
                     | (buf_q[k*flit_width_p +: flit_width_p]
                        & {flit_width_p{cnt_q == len_width_p'(k)}});
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= e_ready;
         cnt_q   <= '0;
         len_q   <= '0;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         buf_q   <= buf_d;
      end
   end

`ifdef BP_ME_WH_ENCODE_ERR_EN
   logic err_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_q | (accept_s & illegal_s);
      end
   end

   assign err_o = err_q;
`else
   logic unused_illegal_s;
   assign unused_illegal_s = illegal_s;
`endif

endmodule

// File: tb/tb_bp_me_wormhole_stream_encode.sv
// Directed bench for bp_me_wormhole_stream_encode with a queue-based packet model.
module tb_bp_me_wormhole_stream_encode;

   localparam int F = 64;
   localparam int H = 93;

   logic         clk = 1'b0;
   logic         reset_i;
   logic [79:0]  msg_hdr_i;
   logic [511:0] data_i;
   logic         has_data_i;
   logic [2:0]   size_i;
   logic [6:0]   cord_i;
   logic [1:0]   cid_i;
   logic         v_i;
   logic         ready_o;
   logic [63:0]  link_data_o;
   logic         link_v_o;
   logic         link_ready_i;
`ifdef BP_ME_WH_ENCODE_ERR_EN
   logic         err_o;
`endif

   always #5 clk = ~clk;

   bp_me_wormhole_stream_encode dut (
      .clk_i        (clk),
      .reset_i      (reset_i),
      .msg_hdr_i    (msg_hdr_i),
      .data_i       (data_i),
      .has_data_i   (has_data_i),
      .size_i       (size_i),
      .cord_i       (cord_i),
      .cid_i        (cid_i),
      .v_i          (v_i),
      .ready_o      (ready_o),
      .link_data_o  (link_data_o),
      .link_v_o     (link_v_o),
      .link_ready_i (link_ready_i)
`ifdef BP_ME_WH_ENCODE_ERR_EN
      ,.err_o       (err_o)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;
   int xfers    = 0;
   logic [63:0] exp_q[$];
   bit err_exp = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int model_bytes(input bit has, input int size);
      int s;
      s = (size > 6) ? 6 : size;
      return has ? (1 << s) : 0;
   endfunction

   function automatic int model_len(input bit has, input int size);
      return ((H + 8 * model_bytes(has, size) + F - 1) / F) - 1;
   endfunction

   function automatic logic [639:0] model_pkt(input logic [6:0] cord, input logic [1:0] cid,
                                              input logic [79:0] msg, input logic [511:0] data,
                                              input bit has, input int size);
      logic [639:0] p;
      int nb;
      p  = '0;
      nb = model_bytes(has, size);
      p[6:0]   = cord;
      p[10:7]  = 4'(model_len(has, size));
      p[12:11] = cid;
      p[92:13] = msg;
      for (int b = 0; b < nb; b++) p[H + 8*b +: 8] = data[8*b +: 8];
      return p;
   endfunction

   // Per-cycle compare: queue non-empty means a flit must be on the link.
   always @(negedge clk) begin
      logic [639:0] p;
      int  L;
      bit  exp_ready;
      if (reset_i) begin
         exp_q.delete();
         err_exp = 1'b0;
      end else begin
         exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && link_ready_i);
         check("link_v", {63'd0, link_v_o}, {63'd0, exp_q.size() != 0});
         check("ready", {63'd0, ready_o}, {63'd0, exp_ready});
         if (exp_q.size() != 0) check("flit", link_data_o, exp_q[0]);
`ifdef BP_ME_WH_ENCODE_ERR_EN
         check("err", {63'd0, err_o}, {63'd0, err_exp});
`endif
         if (exp_q.size() != 0 && link_ready_i) begin
            void'(exp_q.pop_front());
            xfers++;
         end
         if (v_i && exp_ready) begin
            p = model_pkt(cord_i, cid_i, msg_hdr_i, data_i, has_data_i, int'(size_i));
            L = model_len(has_data_i, int'(size_i));
            for (int k = 0; k <= L; k++) exp_q.push_back(p[64*k +: 64]);
            if (has_data_i && size_i > 3'd6) err_exp = 1'b1;
         end
      end
   end

   task automatic send(input logic [6:0] cord, input logic [1:0] cid, input logic [79:0] msg,
                       input logic [511:0] data, input bit has, input logic [2:0] size);
      bit acc;
      acc = 1'b0;
      @(posedge clk); #1;
      cord_i = cord; cid_i = cid; msg_hdr_i = msg; data_i = data;
      has_data_i = has; size_i = size; v_i = 1'b1;
      for (int i = 0; i < 200 && !acc; i++) begin
         @(negedge clk);
         acc = ready_o;
         @(posedge clk); #1;
      end
      check("send_accept", {63'd0, acc}, 64'd1);
      v_i = 1'b0;
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !link_v_o) done = 1'b1;
      end
      check("idle_timeout", {63'd0, done}, 64'd1);
   endtask

   initial begin
      logic [639:0] p;
      logic [511:0] d;
      int vcount;
      int x0;
      reset_i = 1'b1; v_i = 1'b0; link_ready_i = 1'b1;
      msg_hdr_i = '0; data_i = '0; has_data_i = 1'b0; size_i = 3'd0; cord_i = 7'd0; cid_i = 2'd0;
      repeat (3) @(posedge clk);
      #1 reset_i = 1'b0;
      @(negedge clk);
      check("rst_ready", {63'd0, ready_o}, 64'd1);
      check("rst_link_v", {63'd0, link_v_o}, 64'd0);

      // Hand-computed pins on the model itself.
      check("mlen_nodata", 64'(model_len(1'b0, 0)), 64'd1);
      check("mlen_s3", 64'(model_len(1'b1, 3)), 64'd2);
      check("mlen_s6", 64'(model_len(1'b1, 6)), 64'd9);
      check("mlen_s7", 64'(model_len(1'b1, 7)), 64'd9);
      p = model_pkt(7'd5, 2'd1, 80'd0, 512'd0, 1'b0, 0);
      check("mpkt_hdr", 64'(p[12:0]), 64'h885);
      d = '1;
      d[63:0] = 64'h1122334455667788;
      p = model_pkt(7'd3, 2'd2, 80'd0, d, 1'b1, 3);
      check("mpkt_data", p[H +: 64], 64'h1122334455667788);
      check("mpkt_upper0", {63'd0, |p[639:157]}, 64'd0);

      // No-data packet: two flits back to back, then idle.
      send(7'd5, 2'd1, 80'h0, 512'd0, 1'b0, 3'd0);
      @(negedge clk);
      check("nd_flit0_hdr", 64'(link_data_o[12:0]), 64'h885);
      @(negedge clk);
      check("nd_flit1_v", {63'd0, link_v_o}, 64'd1);
      @(negedge clk);
      check("nd_done", {63'd0, link_v_o}, 64'd0);

      // 8-byte payload with garbage in the unused upper bytes.
      for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
      d[63:0] = 64'h1122334455667788;
      send(7'd3, 2'd2, {$urandom, $urandom, 16'h5a5a}, d, 1'b1, 3'd3);
      @(negedge clk);
      @(negedge clk);
      check("s3_flit1_data", 64'(link_data_o[63:29]), 64'h455667788);
      @(negedge clk);
      check("s3_flit2_lo", 64'(link_data_o[28:0]), 64'h02244668);
      check("s3_flit2_hi0", 64'(link_data_o[63:29]), 64'd0);
      wait_idle();

      // 64-byte payload under a toggling link ready.
      for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
      link_ready_i = 1'b0;
      send(7'd9, 2'd3, {$urandom, $urandom, 16'h1234}, d, 1'b1, 3'd6);
      vcount = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (link_v_o) vcount++;
         @(posedge clk); #1;
         link_ready_i = ~link_ready_i;
      end
      link_ready_i = 1'b1;
      check("s6_cycles", 64'(vcount), 64'd20);
      wait_idle();

      // Back-to-back: second packet accepted during the first one's last flit.
      send(7'd1, 2'd0, 80'h77, 512'd0, 1'b0, 3'd0);
      send(7'd2, 2'd1, 80'h88, d, 1'b1, 3'd3);
      @(negedge clk);
      check("b2b_v", {63'd0, link_v_o}, 64'd1);
      check("b2b_len", 64'(link_data_o[10:7]), 64'd2);
      wait_idle();

      // Illegal size clamps to 64 bytes.
      send(7'd4, 2'd2, 80'h99, '1, 1'b1, 3'd7);
      @(negedge clk);
      check("s7_len", 64'(link_data_o[10:7]), 64'd9);
`ifdef BP_ME_WH_ENCODE_ERR_EN
      check("s7_err", {63'd0, err_o}, 64'd1);
`endif
      wait_idle();

      // Reset in the middle of a 10-flit packet.
      send(7'd6, 2'd1, 80'h42, d, 1'b1, 3'd6);
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
      reset_i = 1'b1;
      @(posedge clk); #1;
      reset_i = 1'b0;
      @(negedge clk);
      check("mid_rst_v", {63'd0, link_v_o}, 64'd0);
      check("mid_rst_ready", {63'd0, ready_o}, 64'd1);
      x0 = xfers;
      send(7'd5, 2'd1, 80'h13, 512'd0, 1'b0, 3'd0);
      wait_idle();
      check("post_rst_flits", 64'(xfers - x0), 64'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
